// File: rtl/cmd_fetch_bram.sv
// ----------------------------------------------------------------------------
// cmd_fetch_bram
//
// Command-word store with two views of one memory:
//   * a byte-writable host port (BRAM_*) with a registered, write-first read,
//   * a burst fetch port that returns BURST consecutive words (wrapping at
//     DEPTH-1 -> 0) one cycle after a request is accepted, with a simple
//     valid/ack hand-off that sustains one burst per cycle.
//
// Ports
//   BRAM_clk     in   sole clock, rising edge
//   BRAM_rst     in   asynchronous assert, active-low reset; release is
//                     synchronised internally to BRAM_clk
//   BRAM_en      in   host port enable
//   BRAM_wen     in   [0:3] byte write enables, bit 0 -> BRAM_dout[0:7]
//   BRAM_addr    in   [0:31] host byte address, word = (addr >> 2) mod DEPTH
//   BRAM_dout    in   [0:31] host write data
//   BRAM_din     out  [0:31] host read data, one cycle after BRAM_en
//   fetch_req    in   fetch request
//   fetch_addr   in   AW-bit start word index of the burst
//   fetch_ready  out  a request would be accepted this cycle
//   fetch_valid  out  fetch_data holds an unconsumed burst
//   fetch_data   out  BURST*32 burst, word k at bits [32k+31:32k]
//   fetch_ack    in   consumer takes fetch_data this cycle
//   fetch_flush  in   drop the held burst and any same-cycle request
// ----------------------------------------------------------------------------
module cmd_fetch_bram #(
  parameter int    DEPTH     = 64,
  parameter int    AW        = 6,
  parameter int    BURST     = 4,
  parameter string INIT_FILE = ""
) (
  input  logic                  BRAM_clk,
  input  logic                  BRAM_rst,
  input  logic                  BRAM_en,
  input  logic [0:3]            BRAM_wen,
  input  logic [0:31]           BRAM_addr,
  input  logic [0:31]           BRAM_dout,
  output logic [0:31]           BRAM_din,
  input  logic                  fetch_req,
  input  logic [AW-1:0]         fetch_addr,
  output logic                  fetch_ready,
  output logic                  fetch_valid,
  output logic [BURST*32-1:0]   fetch_data,
  input  logic                  fetch_ack,
  input  logic                  fetch_flush
);

  logic [31:0]         mem [DEPTH];

  logic [1:0]          rst_sync;
  logic                rst_done;

  logic [3:0]          host_wen;
  logic [31:0]         host_wdata;
  logic [AW-1:0]       host_idx;
  logic                host_wr;
  logic [31:0]         host_word;
  logic [31:0]         din_q;

  logic [AW-1:0]       burst_idx;
  logic [BURST*32-1:0] burst;
  logic                accept;
  logic                valid_q;
  logic [BURST*32-1:0] data_q;

  // Memory preload at elaboration: all zero.
  initial begin
    for (int i = 0; i < DEPTH; i++) mem[i] = '0;
  end

  // Reset synchroniser: assertion clears everything at once, release takes
  // effect two edges later so no state leaves reset on a partial cycle.
  // Until rst_done rises, host writes and fetch acceptance are blocked.
  always_ff @(posedge BRAM_clk or negedge BRAM_rst) begin
    if (!BRAM_rst) rst_sync <= 2'b00;
    else           rst_sync <= {rst_sync[0], 1'b1};
  end

  assign rst_done = rst_sync[1];

  // The big-endian-numbered host vectors are copied into little-endian
  // locals by value, so byte lane j below is bits [8j+7:8j] of the word;
  // BRAM_wen[0] therefore lands on lane 3, the BRAM_dout[0:7] byte.
  assign host_wen   = BRAM_wen;
  assign host_wdata = BRAM_dout;
  assign host_idx   = AW'(BRAM_addr >> 2);
  assign host_wr    = rst_done && BRAM_en && (host_wen != 4'b0000);

  // Post-write value of the addressed word. It feeds the memory write, the
  // write-first host read and the collision forward into a new burst.
  always_comb begin
    host_word = mem[host_idx];
    for (int j = 0; j < 4; j++) begin
      if (host_wen[j]) host_word[8*j +: 8] = host_wdata[8*j +: 8];
    end
  end

  // Memory array update; deliberately unaffected by reset or flush.
  always_ff @(posedge BRAM_clk) begin
    if (host_wr) mem[host_idx] <= host_word;
  end

  // Host read register: loads the merged word whenever the port is enabled
  // and holds otherwise.
  always_ff @(posedge BRAM_clk or negedge BRAM_rst) begin
    if (!BRAM_rst)                din_q <= '0;
    else if (rst_done && BRAM_en) din_q <= host_word;
  end

  assign BRAM_din = din_q;

  // Burst assembly. The start index wraps naturally in AW bits. A word that
  // the host writes in the same cycle is taken from the merge path so the
  // burst carries the post-write value.
  always_comb begin
    burst     = '0;
    burst_idx = '0;
    for (int k = 0; k < BURST; k++) begin
      burst_idx = fetch_addr + AW'(k);
      if (host_wr && (host_idx == burst_idx)) burst[32*k +: 32] = host_word;
      else                                    burst[32*k +: 32] = mem[burst_idx];
    end
  end

  // A slot is free when nothing is held or the held burst leaves this cycle;
  // flush and an unfinished reset both close the slot.
  assign fetch_ready = rst_done && (!valid_q || fetch_ack) && !fetch_flush;
  assign accept      = fetch_req && fetch_ready;

  // Burst holding register. Flush wins over everything, a new acceptance
  // replaces the outgoing burst without a bubble, and a lone ack empties it.
  // An ack with nothing held has no effect because valid_q is already 0.
  always_ff @(posedge BRAM_clk or negedge BRAM_rst) begin
    if (!BRAM_rst) begin
      valid_q <= 1'b0;
      data_q  <= '0;
    end else if (fetch_flush) begin
      valid_q <= 1'b0;
    end else if (accept) begin
      valid_q <= 1'b1;
      data_q  <= burst;
    end else if (fetch_ack) begin
      valid_q <= 1'b0;
    end
  end

  assign fetch_valid = valid_q;
  assign fetch_data  = data_q;

endmodule

// File: tb/tb_cmd_fetch_bram.sv
// ----------------------------------------------------------------------------
// tb_cmd_fetch_bram
//
// Self-checking bench for cmd_fetch_bram (DEPTH=64, AW=6, BURST=4).
// A reference model holds the memory as a plain array and describes each
// cycle as "apply the host write, then read everything from the updated
// memory", and the held burst as a single valid flag plus data.
// A hand-computed vector table, directed corner-case sequences and a
// randomized run are all driven through applyStimulus.
// ----------------------------------------------------------------------------
module tb_cmd_fetch_bram;

  localparam int DEPTH = 64;
  localparam int AW    = 6;
  localparam int BURST = 4;
  localparam int DW    = BURST * 32;

  logic          BRAM_clk;
  logic          BRAM_rst;
  logic          BRAM_en;
  logic [0:3]    BRAM_wen;
  logic [0:31]   BRAM_addr;
  logic [0:31]   BRAM_dout;
  logic [0:31]   BRAM_din;
  logic          fetch_req;
  logic [AW-1:0] fetch_addr;
  logic          fetch_ready;
  logic          fetch_valid;
  logic [DW-1:0] fetch_data;
  logic          fetch_ack;
  logic          fetch_flush;

  typedef struct {
    logic          en;
    logic [0:3]    wen;
    logic [0:31]   addr;
    logic [0:31]   dout;
    logic          req;
    logic [AW-1:0] faddr;
    logic          ack;
    logic          flush;
  } stim_t;

  typedef struct {
    stim_t       s;
    logic        exp_ready;
    logic        exp_valid;
    logic [31:0] exp_din;
    logic [31:0] exp_w0;
    logic [31:0] exp_w1;
  } vec_t;

  // Reference model state
  logic [0:31]   m_mem [DEPTH];
  logic          m_valid;
  logic [DW-1:0] m_data;
  logic [0:31]   m_din;

  int n_cmp;
  int n_fail;

  cmd_fetch_bram #(
    .DEPTH    (DEPTH),
    .AW       (AW),
    .BURST    (BURST),
    .INIT_FILE("")
  ) dut (
    .BRAM_clk   (BRAM_clk),
    .BRAM_rst   (BRAM_rst),
    .BRAM_en    (BRAM_en),
    .BRAM_wen   (BRAM_wen),
    .BRAM_addr  (BRAM_addr),
    .BRAM_dout  (BRAM_dout),
    .BRAM_din   (BRAM_din),
    .fetch_req  (fetch_req),
    .fetch_addr (fetch_addr),
    .fetch_ready(fetch_ready),
    .fetch_valid(fetch_valid),
    .fetch_data (fetch_data),
    .fetch_ack  (fetch_ack),
    .fetch_flush(fetch_flush)
  );

  // Free-running clock, rising edges at 5, 15, 25, ...
  initial BRAM_clk = 1'b0;
  always #5 BRAM_clk = ~BRAM_clk;

  task automatic checkOutput(input string name, input logic [DW-1:0] act,
                             input logic [DW-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic stim_t mk(input logic en, input logic [0:3] wen,
                               input logic [0:31] addr, input logic [0:31] dout,
                               input logic req, input logic [AW-1:0] faddr,
                               input logic ack, input logic flush);
    stim_t s;
    s.en = en; s.wen = wen; s.addr = addr; s.dout = dout;
    s.req = req; s.faddr = faddr; s.ack = ack; s.flush = flush;
    return s;
  endfunction

  function automatic stim_t idle();
    return mk(1'b0, 4'b0000, 32'h0, 32'h0, 1'b0, '0, 1'b0, 1'b0);
  endfunction

  // Drives one cycle starting just after a rising edge. When chk is set the
  // combinational ready and the post-edge outputs are compared to the model.
  task automatic applyStimulus(input stim_t s, input bit chk, output logic rdy_seen);
    int          hi;
    logic [0:31] w;
    logic        exp_ready;
    BRAM_en     = s.en;
    BRAM_wen    = s.wen;
    BRAM_addr   = s.addr;
    BRAM_dout   = s.dout;
    fetch_req   = s.req;
    fetch_addr  = s.faddr;
    fetch_ack   = s.ack;
    fetch_flush = s.flush;
    #1;
    rdy_seen  = fetch_ready;
    exp_ready = (!m_valid || s.ack) && !s.flush;
    if (chk) checkOutput("ready", DW'(fetch_ready), DW'(exp_ready));
    // Model: the host write happens first, every read sees the result.
    hi = int'((s.addr >> 2) % 32'(DEPTH));
    w  = m_mem[hi];
    if (s.en && (s.wen != 4'b0000)) begin
      for (int j = 0; j < 4; j++)
        if (s.wen[j]) w[8*j +: 8] = s.dout[8*j +: 8];
      m_mem[hi] = w;
    end
    if (s.en) m_din = m_mem[hi];
    if (s.flush) begin
      m_valid = 1'b0;
    end else if (s.req && exp_ready) begin
      m_valid = 1'b1;
      for (int k = 0; k < BURST; k++)
        m_data[32*k +: 32] = m_mem[(int'(s.faddr) + k) % DEPTH];
    end else if (s.ack) begin
      m_valid = 1'b0;
    end
    @(posedge BRAM_clk);
    #1;
    if (chk) begin
      checkOutput("valid", DW'(fetch_valid), DW'(m_valid));
      checkOutput("din", DW'(BRAM_din), DW'(m_din));
      if (m_valid) checkOutput("data", fetch_data, m_data);
    end
  endtask

  vec_t  tbl [8];
  stim_t s;
  logic  rdy;
  logic [DW-1:0] held;

  initial begin
    n_cmp  = 0;
    n_fail = 0;
    for (int i = 0; i < DEPTH; i++) m_mem[i] = '0;
    m_valid = 1'b0;
    m_data  = '0;
    m_din   = '0;

    // Hand-computed vectors, starting from an all-zero memory.
    tbl[0].s = mk(1, 4'b1111, 32'h20,   32'h12345678, 1, 6'd7, 0, 0);
    tbl[0].exp_ready = 1; tbl[0].exp_valid = 1; tbl[0].exp_din = 32'h12345678;
    tbl[0].exp_w0 = 32'h0;        tbl[0].exp_w1 = 32'h12345678;
    tbl[1].s = mk(1, 4'b0000, 32'h20,   32'h0,        1, 6'd8, 0, 0);
    tbl[1].exp_ready = 0; tbl[1].exp_valid = 1; tbl[1].exp_din = 32'h12345678;
    tbl[1].exp_w0 = 32'h0;        tbl[1].exp_w1 = 32'h12345678;
    tbl[2].s = mk(0, 4'b0000, 32'h0,    32'h0,        1, 6'd8, 1, 0);
    tbl[2].exp_ready = 1; tbl[2].exp_valid = 1; tbl[2].exp_din = 32'h12345678;
    tbl[2].exp_w0 = 32'h12345678; tbl[2].exp_w1 = 32'h0;
    tbl[3].s = mk(1, 4'b0001, 32'h24,   32'hFFFFFFAB, 0, 6'd0, 1, 0);
    tbl[3].exp_ready = 1; tbl[3].exp_valid = 0; tbl[3].exp_din = 32'h000000AB;
    tbl[3].exp_w0 = 32'h0;        tbl[3].exp_w1 = 32'h0;
    tbl[4].s = mk(0, 4'b0000, 32'h0,    32'h0,        1, 6'd9, 0, 1);
    tbl[4].exp_ready = 0; tbl[4].exp_valid = 0; tbl[4].exp_din = 32'h000000AB;
    tbl[4].exp_w0 = 32'h0;        tbl[4].exp_w1 = 32'h0;
    tbl[5].s = mk(0, 4'b0000, 32'h0,    32'h0,        1, 6'd9, 1, 0);
    tbl[5].exp_ready = 1; tbl[5].exp_valid = 1; tbl[5].exp_din = 32'h000000AB;
    tbl[5].exp_w0 = 32'h000000AB; tbl[5].exp_w1 = 32'h0;
    tbl[6].s = mk(1, 4'b0110, 32'h1020, 32'hCAFEF00D, 1, 6'd7, 1, 0);
    tbl[6].exp_ready = 1; tbl[6].exp_valid = 1; tbl[6].exp_din = 32'h12FEF078;
    tbl[6].exp_w0 = 32'h0;        tbl[6].exp_w1 = 32'h12FEF078;
    tbl[7].s = mk(0, 4'b0000, 32'h0,    32'h0,        0, 6'd0, 1, 0);
    tbl[7].exp_ready = 1; tbl[7].exp_valid = 0; tbl[7].exp_din = 32'h12FEF078;
    tbl[7].exp_w0 = 32'h0;        tbl[7].exp_w1 = 32'h0;

    // Reset state, visible before any clock edge.
    BRAM_rst = 1'b0;
    s = idle();
    BRAM_en = 0; BRAM_wen = '0; BRAM_addr = '0; BRAM_dout = '0;
    fetch_req = 1; fetch_addr = '0; fetch_ack = 1; fetch_flush = 0;
    #2;
    checkOutput("rst_valid", DW'(fetch_valid), DW'(1'b0));
    checkOutput("rst_data", fetch_data, '0);
    checkOutput("rst_din", DW'(BRAM_din), DW'(32'h0));
    checkOutput("rst_ready", DW'(fetch_ready), DW'(1'b0));
    @(posedge BRAM_clk);
    #1;
    BRAM_rst = 1'b1;
    for (int i = 0; i < 3; i++) applyStimulus(idle(), 0, rdy);

    $display("[TB] vector table");
    for (int i = 0; i < 8; i++) begin
      applyStimulus(tbl[i].s, 1, rdy);
      checkOutput($sformatf("tbl%0d_ready", i), DW'(rdy), DW'(tbl[i].exp_ready));
      checkOutput($sformatf("tbl%0d_valid", i), DW'(fetch_valid), DW'(tbl[i].exp_valid));
      checkOutput($sformatf("tbl%0d_din", i), DW'(BRAM_din), DW'(tbl[i].exp_din));
      if (tbl[i].exp_valid) begin
        checkOutput($sformatf("tbl%0d_w0", i), DW'(fetch_data[31:0]), DW'(tbl[i].exp_w0));
        checkOutput($sformatf("tbl%0d_w1", i), DW'(fetch_data[63:32]), DW'(tbl[i].exp_w1));
      end
    end

    $display("[TB] byte write");
    applyStimulus(mk(1, 4'b1111, 32'h10, 32'hAABBCCDD, 0, 6'd0, 0, 0), 1, rdy);
    applyStimulus(mk(1, 4'b1000, 32'h10, 32'h11000000, 0, 6'd0, 0, 0), 1, rdy);
    applyStimulus(mk(1, 4'b0000, 32'h10, 32'h0,        0, 6'd0, 0, 0), 1, rdy);
    checkOutput("byte_merge", DW'(BRAM_din), DW'(32'h11BBCCDD));

    $display("[TB] wrap fetch");
    applyStimulus(mk(1, 4'b1111, 32'd248, 32'hA0A0A0A0, 0, 6'd0, 0, 0), 1, rdy);
    applyStimulus(mk(1, 4'b1111, 32'd252, 32'hB0B0B0B0, 0, 6'd0, 0, 0), 1, rdy);
    applyStimulus(mk(1, 4'b1111, 32'd0,   32'hC0C0C0C0, 0, 6'd0, 0, 0), 1, rdy);
    applyStimulus(mk(1, 4'b1111, 32'd4,   32'hD0D0D0D0, 0, 6'd0, 0, 0), 1, rdy);
    applyStimulus(mk(0, 4'b0000, 32'd0,   32'h0,        1, 6'd62, 0, 0), 1, rdy);
    checkOutput("wrap_valid", DW'(fetch_valid), DW'(1'b1));
    held = {32'hD0D0D0D0, 32'hC0C0C0C0, 32'hB0B0B0B0, 32'hA0A0A0A0};
    checkOutput("wrap_data", fetch_data, held);

    $display("[TB] backpressure");
    for (int i = 0; i < 3; i++) begin
      applyStimulus(mk(0, 4'b0000, 32'd0, 32'h0, 1, 6'd20, 0, 0), 1, rdy);
      checkOutput($sformatf("bp%0d_ready", i), DW'(rdy), DW'(1'b0));
      checkOutput($sformatf("bp%0d_data", i), fetch_data, held);
    end
    applyStimulus(mk(0, 4'b0000, 32'd0, 32'h0, 1, 6'd0, 1, 0), 1, rdy);
    checkOutput("stream_ready", DW'(rdy), DW'(1'b1));
    checkOutput("stream_valid", DW'(fetch_valid), DW'(1'b1));
    checkOutput("stream_data", fetch_data, {32'h0, 32'h0, 32'hD0D0D0D0, 32'hC0C0C0C0});

    $display("[TB] collision");
    applyStimulus(mk(1, 4'b1111, 32'd20, 32'hDEADBEEF, 1, 6'd4, 1, 0), 1, rdy);
    checkOutput("collide_w1", DW'(fetch_data[63:32]), DW'(32'hDEADBEEF));
    checkOutput("collide_data", fetch_data, {32'h0, 32'h0, 32'hDEADBEEF, 32'h11BBCCDD});

    $display("[TB] flush and reset");
    applyStimulus(mk(0, 4'b0000, 32'd0, 32'h0, 1, 6'd10, 0, 1), 1, rdy);
    checkOutput("flush_ready", DW'(rdy), DW'(1'b0));
    checkOutput("flush_valid", DW'(fetch_valid), DW'(1'b0));
    applyStimulus(mk(0, 4'b0000, 32'd0, 32'h0, 1, 6'd62, 0, 0), 1, rdy);
    checkOutput("refetch_valid", DW'(fetch_valid), DW'(1'b1));
    // Reset pulse between edges, with a write and a request on the inputs.
    BRAM_rst = 1'b0;
    BRAM_en = 1; BRAM_wen = 4'b1111; BRAM_addr = 32'd248; BRAM_dout = 32'h0BAD0BAD;
    fetch_req = 1; fetch_addr = 6'd0; fetch_ack = 1; fetch_flush = 0;
    #1;
    checkOutput("pulse_valid", DW'(fetch_valid), DW'(1'b0));
    checkOutput("pulse_data", fetch_data, '0);
    checkOutput("pulse_din", DW'(BRAM_din), DW'(32'h0));
    checkOutput("pulse_ready", DW'(fetch_ready), DW'(1'b0));
    #2;
    BRAM_rst = 1'b1;
    #1;
    BRAM_rst = 1'b0;
    // Held across an edge: the write and the request must both be ignored.
    @(posedge BRAM_clk);
    #1;
    checkOutput("rsthold_valid", DW'(fetch_valid), DW'(1'b0));
    checkOutput("rsthold_din", DW'(BRAM_din), DW'(32'h0));
    checkOutput("rsthold_ready", DW'(fetch_ready), DW'(1'b0));
    BRAM_rst = 1'b1;
    m_valid = 1'b0;
    m_data  = '0;
    m_din   = '0;
    for (int i = 0; i < 3; i++) applyStimulus(idle(), 0, rdy);
    applyStimulus(mk(1, 4'b0000, 32'd248, 32'h0, 1, 6'd62, 0, 0), 1, rdy);
    checkOutput("post_rst_data", fetch_data, held);
    checkOutput("post_rst_din", DW'(BRAM_din), DW'(32'hA0A0A0A0));

    $display("[TB] random run");
    for (int i = 0; i < 400; i++) begin
      s.en    = ($urandom_range(0, 9) < 7);
      s.wen   = 4'($urandom);
      s.addr  = ($urandom & 32'hFFFFF000) | (32'($urandom_range(0, 15)) << 2)
                | 32'($urandom_range(0, 3));
      if ($urandom_range(0, 3) == 0) s.addr = $urandom;
      s.dout  = $urandom;
      s.req   = ($urandom_range(0, 9) < 7);
      s.faddr = ($urandom_range(0, 1) == 0) ? AW'($urandom_range(0, 15)) : AW'($urandom);
      s.ack   = ($urandom_range(0, 9) < 6);
      s.flush = ($urandom_range(0, 9) == 0);
      applyStimulus(s, 1, rdy);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/cmd_fetch_bram.md
CMD_FETCH_BRAM -- requirements
Module: cmd_fetch_bram

Interface
REQ-001 Parameter DEPTH, 64, number of 32-bit command words; SHALL be a power of two, 16..1024.
REQ-002 Parameter AW, 6, word-index width; SHALL equal log2(DEPTH).
REQ-003 Parameter BURST, 4, words returned per fetch; SHALL be 1..8.
REQ-004 Parameter INIT_FILE, "" (empty), hex image loaded into memory at elaboration; empty means all words are 0.
REQ-005 BRAM_clk  in  1  sole clock; all state SHALL update on its rising edge.
REQ-006 BRAM_rst  in  1  reset, asynchronous assert, active-low; deassertion SHALL be synchronous to BRAM_clk.
REQ-007 BRAM_en  in  1  host port enable.
REQ-008 BRAM_wen  in  [0:3]  host byte write enables; bit 0 selects BRAM_dout[0:7], bit 3 selects BRAM_dout[24:31].
REQ-009 BRAM_addr  in  [0:31]  host byte address; word index = (BRAM_addr >> 2) mod DEPTH.
REQ-010 BRAM_dout  in  [0:31]  host write data.
REQ-011 BRAM_din  out  [0:31]  host read data.
REQ-012 fetch_req  in  1  fetch request.
REQ-013 fetch_addr  in  AW  start word index of the burst.
REQ-014 fetch_ready  out  1  request can be accepted this cycle.
REQ-015 fetch_valid  out  1  fetch_data holds an unconsumed burst.
REQ-016 fetch_data  out  BURST*32  burst; word k SHALL occupy bits [32k+31:32k].
REQ-017 fetch_ack  in  1  consumer takes fetch_data this cycle.
REQ-018 fetch_flush  in  1  discard the held burst and any same-cycle request.

Function
REQ-019 Host write: when BRAM_en=1 and any BRAM_wen bit=1, only the enabled byte lanes of the addressed word SHALL be updated at the clock edge.
REQ-020 Host read: when BRAM_en=1, BRAM_din SHALL present the addressed word one cycle later. The value SHALL be write-first, i.e. include the same-cycle byte merge.
REQ-021 When BRAM_en=0, BRAM_din SHALL hold its previous value.
REQ-022 Address bits above the word index SHALL be ignored; addresses alias modulo DEPTH.
REQ-023 fetch_ready SHALL equal (!fetch_valid || fetch_ack) && !fetch_flush.
REQ-024 A fetch is accepted when fetch_req=1 and fetch_ready=1.
REQ-025 On the edge after acceptance: fetch_valid SHALL be 1, and word k of fetch_data SHALL be mem[(fetch_addr+k) mod DEPTH]. Latency is 1 cycle, with wrap-around at DEPTH-1 -> 0.
REQ-026 Back-to-back operation: accept and ack in the same cycle SHALL load the new burst with no bubble. Sustained throughput SHALL be one burst per cycle.
REQ-027 When fetch_ack=1 and no request is accepted, fetch_valid SHALL clear on the next edge.
REQ-028 fetch_data SHALL remain stable while fetch_valid=1 and fetch_ack=0.
REQ-029 fetch_ack while fetch_valid=0 SHALL be ignored.
REQ-030 Collision: a host write in the acceptance cycle to any word inside the burst window SHALL be forwarded. The burst SHALL carry the post-write merged word.
REQ-031 Host writes after acceptance SHALL NOT alter a held burst.
REQ-032 fetch_flush=1 SHALL clear fetch_valid on the next edge and SHALL block acceptance that cycle. fetch_flush SHALL take priority over fetch_req and fetch_ack.
REQ-033 Memory contents SHALL NOT be affected by reset or flush.

Reset
REQ-034 While BRAM_rst=0: fetch_valid=0, fetch_data=0, BRAM_din=0, fetch_ready=0. All of these SHALL take effect immediately, without a clock.
REQ-035 Reset asserted mid-burst SHALL discard the held burst; no fetch SHALL be accepted while BRAM_rst=0.
REQ-036 Host writes SHALL be ignored while BRAM_rst=0.
REQ-037 After deassertion, the first accepted fetch SHALL return the memory contents as they were before reset.

Verification
REQ-038 Byte write: DEPTH=64. Write 0xAABBCCDD to byte address 0x10 with wen=1111, then write 0x11000000 with wen=1000, then read -> BRAM_din=0x11BBCCDD one cycle after the read.
REQ-039 Wrap fetch: BURST=4, mem[62]=A, mem[63]=B, mem[0]=C, mem[1]=D. fetch_addr=62 -> next cycle fetch_valid=1 and fetch_data words 0..3 = A,B,C,D.
REQ-040 Backpressure/stream: hold fetch_ack=0 for 3 cycles -> fetch_ready=0 and fetch_data unchanged. Then issue ack with a new request -> new burst loaded on the next edge and fetch_valid stays 1.
REQ-041 Collision: in one cycle, write mem[5]=0xDEADBEEF with wen=1111 and accept a fetch at addr 4 -> fetch_data word 1 = 0xDEADBEEF.
REQ-042 Flush/reset: with fetch_valid=1, assert fetch_flush together with fetch_req -> next cycle fetch_valid=0 and no burst loaded. Then pulse BRAM_rst low between edges -> outputs 0 immediately, and memory contents are intact on the next fetch.
